dff_c2sif_arb: RTL

DFF_C2SIF_ARB -- requirements
Module: dff_c2sif_arb

---
 rtl/dff_c2sif_arb.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dff_c2sif_arb.sv
// dff_c2sif_arb: round-robin arbiter that lets NREQ requesters share one
// external single-bit dff in committed bursts, and returns the dff response
// tagged with its owner.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req        per-requester access request
//   len        per-requester burst length, LEN_W bits each (0 acts as 1)
//   din_in     per-requester data bit for the shared dff
//   gnt        registered one-hot grant
//   busy       high while a burst or the post-burst gap is in progress
//   din        data to the shared dff (0 when nothing is granted)
//   dout       shared dff output, one cycle behind din
//   dout_out   registered copy of dout
//   dout_vld   one-hot owner tag of dout_out
//   done       one-cycle pulse with the last dout_vld of a burst
module dff_c2sif_arb #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 4,
    parameter int GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    input  logic [NREQ-1:0]       din_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  din,
    input  logic                  dout,
    output logic                  dout_out,
    output logic [NREQ-1:0]       dout_vld,
    output logic [NREQ-1:0]       done
);

    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
    localparam logic [2:0] GAP_LD = 3'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q, last_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [2:0]       gap_q, gap_d;

    // Return pipeline: tag/last follow the driven bit through the dff
    // stage, vld/done/dout_out then line up with the registered response.
    logic [NREQ-1:0]  tag_q, tag_d;
    logic             tlast_q, tlast_d;
    logic             dout_out_q, dout_out_d;
    logic [NREQ-1:0]  vld_q, vld_d;
    logic [NREQ-1:0]  done_q, done_d;

    logic             found;
    logic [IW-1:0]    win;
    logic [IW-1:0]    cand;
    logic [LEN_W-1:0] win_len;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                win_len = len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        tag_d      = gnt_q;
        tlast_d    = 1'b0;
        dout_out_d = dout;
        vld_d      = tag_q;
        done_d     = tag_q & {NREQ{tlast_q}};

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_BURST;
                    gnt_d   = NREQ'(1) << win;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = (win_len == '0) ? LEN_W'(1) : win_len;
                end
            end
            S_BURST: begin
                cnt_d   = cnt_q - LEN_W'(1);
                tlast_d = (cnt_q == LEN_W'(1));
                if (cnt_q == LEN_W'(1)) begin
                    state_d = S_GAP;
                    gnt_d   = '0;
                    gap_d   = GAP_LD;
                end
            end
            S_GAP: begin
                gap_d = gap_q - 3'd1;
                if (gap_q == 3'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            last_q     <= LAST_RST;
            cnt_q      <= '0;
            gap_q      <= '0;
            tag_q      <= '0;
            tlast_q    <= 1'b0;
            dout_out_q <= 1'b0;
            vld_q      <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            tag_q      <= tag_d;
            tlast_q    <= tlast_d;
            dout_out_q <= dout_out_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != S_IDLE);
    assign din      = (|gnt_q) ? din_in[owner_q] : 1'b0;
    assign dout_out = dout_out_q;
    assign dout_vld = vld_q;
    assign done     = done_q;

endmodule
